// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the 7-segment scan controller
package seg7_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - hex nibble to active-low segment lookup
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure table lookup; no registers here, the caller registers the result
    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - multiplexed 7-segment scan with dead time and frame-aligned commit
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500,
    localparam int DW          = 5 * N_DIGITS,
    localparam int DSW         = $clog2(N_DIGITS)
) (
    input  logic                clck_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                hold_i,
    input  logic                wr_valid_i,
    input  logic [DW-1:0]       wr_data_i,
    output logic                wr_ready_o,
    output logic [N_DIGITS-1:0] an_o,
    output logic [6:0]          seg_o,
    output logic                dp_o,
    output logic [DSW-1:0]      digit_sel_o,
    output logic                frame_o
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0]  PRE_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DSW-1:0] DIG_LAST   = DSW'(N_DIGITS - 1);

    scan_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DSW-1:0]       dig_q, dig_d;
    logic                 boundary;

    logic [DW-1:0]        disp_q;
    logic [DW-1:0]        pend_q;
    logic                 pend_v;
    logic                 accept;
    logic                 commit;

    logic [3:0]           nibble;
    logic [6:0]           dec_seg;
    logic [N_DIGITS-1:0]  dp_mask;

    logic [N_DIGITS-1:0]  an_d;
    logic [6:0]           seg_d;
    logic                 dp_d;
    logic [DSW-1:0]       sel_d;
    logic                 frame_d;

    assign wr_ready_o = ~pend_v;
    assign accept     = wr_valid_i & ~pend_v;
    assign commit     = pend_v & (boundary | ~enable_i);
    assign dp_mask    = disp_q[DW-1:4*N_DIGITS];

    // Select the nibble of the shown value that belongs to the current digit
    always_comb begin
        nibble = 4'h0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (dig_q == DSW'(k)) begin
                nibble = disp_q[4*k +: 4];
            end
        end
    end

    seg7_hex_decoder u_dec (
        .hex (nibble),
        .seg (dec_seg)
    );

    // Scan state, prescaler and digit index registers
    always_ff @(posedge clck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_BLANK;
            cnt_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
        end
    end

    // Next scan position: disable parks at blank/digit 0, hold freezes everything
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        boundary = 1'b0;
        if (!enable_i) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            dig_d   = '0;
        end else if (!hold_i) begin
            case (state_q)
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        if (dig_q == DIG_LAST) begin
                            dig_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            dig_d = dig_q + DSW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pending slot and shown value; commit only at frame boundary or while disabled
    always_ff @(posedge clck_i or posedge rst_i) begin
        if (rst_i) begin
            disp_q <= '0;
            pend_q <= '0;
            pend_v <= 1'b0;
        end else if (commit) begin
            disp_q <= pend_q;
            pend_v <= 1'b0;
        end else if (accept) begin
            pend_q <= wr_data_i;
            pend_v <= 1'b1;
        end
    end

    // Output values derived from the current scan position; held values by default
    always_comb begin
        an_d    = an_o;
        seg_d   = seg_o;
        dp_d    = dp_o;
        sel_d   = digit_sel_o;
        frame_d = 1'b0;
        if (!enable_i) begin
            an_d  = '1;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
            sel_d = '0;
        end else if (!hold_i) begin
            sel_d   = dig_q;
            frame_d = boundary;
            if (state_q == S_DRIVE) begin
                an_d  = ~(N_DIGITS'(1) << dig_q);
                seg_d = dec_seg;
                dp_d  = ~dp_mask[dig_q];
            end else begin
                an_d  = '1;
                seg_d = SEG_OFF;
                dp_d  = 1'b1;
            end
        end
    end

    // Registered display outputs
    always_ff @(posedge clck_i or posedge rst_i) begin
        if (rst_i) begin
            an_o        <= '1;
            seg_o       <= SEG_OFF;
            dp_o        <= 1'b1;
            digit_sel_o <= '0;
            frame_o     <= 1'b0;
        end else begin
            an_o        <= an_d;
            seg_o       <= seg_d;
            dp_o        <= dp_d;
            digit_sel_o <= sel_d;
            frame_o     <= frame_d;
        end
    end

endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Scan controller for the multiplexed 7-segment display peripheral of the mono-cycle CPU. Takes a packed hex value plus decimal-point mask from the CPU store path through a valid/ready handshake and time-multiplexes it across N_DIGITS common-anode digits. Inserts an all-off dead time between digits to suppress ghosting. Commits new data only at frame boundaries, so the display never shows a torn value.

## Interface
- N_DIGITS, 4, digits scanned; legal range 2..8.
- PRESCALE, 50000, clock cycles each digit is driven; must be ≥ 2.
- BLANK_CYCLES, 500, clock cycles all anodes are off before each digit; must be ≥ 1.
- DW, derived as 5*N_DIGITS, write data width.
- clck_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  scan enable; low blanks the display and parks the scan.
- hold_i  in  1  freeze scan position and outputs.
- wr_valid_i  in  1  CPU write request.
- wr_data_i  in  DW  [4N-1:0] hex nibbles, digit k = [4k+3:4k]; [5N-1:4N] decimal points, bit 4N+k = digit k.
- wr_ready_o  out  1  pending slot free.
- an_o  out  N_DIGITS  anode enables, active-low.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_o  out  1  decimal point, active-low.
- digit_sel_o  out  $clog2(N_DIGITS)  current digit index.
- frame_o  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - disp_q (DW): shown value.
  - pend_q (DW) with pend_v: pending value and its valid flag.
  - cnt_q: prescaler.
  - dig_q: digit index.
  - state_q: scan state.
- Reset values:
  - an_o all ones, seg_o 7'h7F, dp_o 1, digit_sel_o 0, frame_o 0, wr_ready_o 1.
  - disp_q 0, pend_v 0, cnt_q 0, state S_BLANK.
- wr_ready_o = !pend_v.
- Accept a write on a cycle with wr_valid_i && wr_ready_o: pend_q <= wr_data_i, pend_v <= 1. Writes are accepted regardless of enable_i and hold_i.
- FSM:
  - S_BLANK: an_o all ones. cnt_q counts 0..BLANK_CYCLES-1, then go to S_DRIVE with cnt_q = 0.
  - S_DRIVE: an_o[dig_q] = 0, all other anodes 1. seg_o/dp_o are the decode of digit dig_q of disp_q. cnt_q counts 0..PRESCALE-1, then go to S_BLANK with cnt_q = 0.
  - Leaving S_DRIVE with dig_q = N_DIGITS-1 is the frame boundary: dig_q wraps to 0 and frame_o pulses. If pend_v, then disp_q <= pend_q and pend_v <= 0.
  - Leaving S_DRIVE otherwise: dig_q increments.
- hold_i = 1 (with enable_i = 1):
  - cnt_q, dig_q, state_q and all display outputs keep their values.
  - No commit takes place, and frame_o stays 0.
- enable_i = 0 (priority over hold_i):
  - an_o all ones, seg_o 7'h7F, dp_o 1.
  - state forced to S_BLANK with cnt_q = 0 and dig_q = 0.
  - If pend_v, commit pend_q to disp_q on the next edge.
- A commit and an accept never collide, because ready is low while pend_v is set.
- Decoder, hex to active-low segments:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- dp_o = !disp_q[4N+dig_q] during S_DRIVE, 1 otherwise.

## Timing
- All outputs are registered, so they change one cycle after the state/counter edge that causes them.
- Frame period = N_DIGITS*(BLANK_CYCLES+PRESCALE) cycles while enabled and not held. Holding extends it by the held cycles.
- Write-to-display latency is at most one frame plus 1 cycle when enabled, and 2 cycles when disabled.
- wr_ready_o falls the cycle after an accept. It rises the cycle after the commit.
- Deasserting rst_i mid-frame restarts at S_BLANK, digit 0, and discards any pending write.

## Structure
- seg7_pkg holds:
  - scan_state_t enum {S_BLANK, S_DRIVE}.
  - SEG_OFF = 7'h7F.
  - The 16-entry segment constant table.
- Sub-module seg7_hex_decoder: combinational 4-bit to 7-bit lookup from seg7_pkg, instantiated once on the muxed nibble.

## Test plan
All scenarios use N_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, giving a 20-cycle frame.
- Reset/idle: assert rst_i asynchronously mid-cycle → an_o=4'hF, seg_o=7'h7F, wr_ready_o=1 immediately. After release, digits 0..3 each show 1000000 ("0") for 4 cycles, with 1-cycle blanks.
- Write and commit: write 20'h0_8A3F while the display is mid-frame.
  - wr_ready_o=0 until the frame boundary.
  - The next frame shows F, 3, A, 8 on an_o=1110, 1101, 1011, 0111.
  - frame_o pulses once per 20 cycles.
- Back-pressure: hold wr_valid_i high with two values back to back → the second is accepted only on the cycle after the first commit, and the first value is displayed for a full frame.
- Hold: assert hold_i for 7 cycles during digit 2 → an_o=1011 and seg_o unchanged throughout. The frame_o period becomes 27 cycles, and a pending value is not committed during the hold.
- Enable off: drop enable_i with a write pending → an_o=4'hF and seg_o=7'h7F next cycle, and the commit happens 2 cycles after the accept. On re-enable the scan restarts at digit 0 after a 1-cycle blank.
- Decimal points: write 20'hA_0000 → dp_o=0 only while digits 1 and 3 are driven, 1 during blanks.
